// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned PROD_W    = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier with fixed WIDTH-cycle latency.
// One operand pair is accepted per start; the product is held until the next completion.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   product_lo,
  output logic               ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e            state_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PW-1:0]     product_q;
  logic              ovf_q;
  logic [PW-1:0]     acc_d;

  // Conditional partial-product add for the current multiplier bit.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Control FSM and shift-add datapath; completion edge captures the sum including its own add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= PW'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_q <= acc_d;
            ovf_q     <= |acc_d[PW-1:WIDTH];
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign product    = product_q;
  assign product_lo = product_q[WIDTH-1:0];
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed scenarios plus random operands
// compared against plain integer multiplication.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] product_lo;
  logic        ovf;

  int unsigned vectors;
  int unsigned miscompares;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .product_lo (product_lo),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns positioned 1 time unit after the accept edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, bounded; optionally inject a start pulse at a given RUN cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp_p, input int inject_at);
    int n;
    n = 0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 40) begin
      if (inject_at > 0 && n == inject_at - 1) begin
        a = 16'd2; b = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd16);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_product"}, 64'(product), 64'(exp_p));
    check({tag, "_lo"}, 64'(product_lo), 64'(exp_p[15:0]));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_p[31:16] != 16'd0));
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] held;
    int          seen;

    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    #13;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 3*5
    launch(16'h0003, 16'h0005);
    wait_done("m3x5", ref_mul(16'h0003, 16'h0005), 0);
    @(posedge clk); #1;
    check("m3x5_done_once", 64'(done), 64'd0);

    // Max operands
    launch(16'hFFFF, 16'hFFFF);
    wait_done("max", ref_mul(16'hFFFF, 16'hFFFF), 0);
    check("max_const", 64'(product), 64'h0000_0000_FFFE_0001);

    // Zero multiplier, then hold
    launch(16'h1234, 16'h0000);
    wait_done("zero", 32'd0, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("zero_hold_done", 64'(seen), 64'd0);
    check("zero_hold_product", 64'(product), 64'd0);
    check("zero_hold_busy", 64'(busy), 64'd0);

    // Start while busy is ignored
    launch(16'd7, 16'd9);
    wait_done("ignore", ref_mul(16'd7, 16'd9), 5);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("ignore_no_second_done", 64'(seen), 64'd0);
    check("ignore_product_held", 64'(product), 64'd63);

    // Reset mid-operation
    launch(16'd100, 16'd200);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    launch(16'd10, 16'd10);
    wait_done("after_rst", 32'd100, 0);

    // Back-to-back: start held through DONE
    launch(16'd300, 16'd7);
    wait_done("b2b_first", ref_mul(16'd300, 16'd7), 0);
    launch(16'h0100, 16'h0100);
    check("b2b_product_kept", 64'(product), 64'(ref_mul(16'd300, 16'd7)));
    wait_done("b2b_second", 32'h0001_0000, 0);

    // Random operands, mixed idle gaps and back-to-back launches
    for (int i = 0; i < 12; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 4 == 3) y = 16'hFFFF;
      held = product;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
      launch(x, y);
      check("rnd_product_not_cleared", 64'(product), 64'(held));
      wait_done("rnd", ref_mul(x, y), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
